// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and default sizes for the round-robin decode arbiter.
package rr_decode_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int unsigned SEL_W_DEF = 4;
    localparam int unsigned N_REQ_DEF = 16;
    // Hold counter width; must be wide enough to represent HOLD_MAX.
    localparam int unsigned CNT_W     = 8;

endpackage

// File: rtl/rr_decode_arbiter_decoder_4to16.sv
// SEL_W-to-N_REQ one-hot decoder; all-zero output while disabled.
module decoder_4to16
    import rr_decode_arbiter_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF,
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o = N_REQ'(1) << sel_i;
        end
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter with one-hot decoded grant and 1-cycle grant latency.
// Optional forced release after HOLD_MAX busy cycles under RR_ARB_TIMEOUT_EN.
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned HOLD_MAX = 255
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_REQ-1:0] Req,
    input  logic             Release,
    output logic [N_REQ-1:0] Grant,
    output logic [SEL_W-1:0] Grant_Idx,
    output logic             Grant_Valid,
    output logic             Timeout
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             hold_expired;

    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;

`ifdef RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX));
`else
    logic unused_hold_max;
    assign unused_hold_max = ^HOLD_MAX;
    assign hold_expired    = 1'b0;
`endif

    // First set request searching upward from last_q+1, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = last_q + SEL_W'(1) + SEL_W'(i);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                    valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = CNT_W'(1);
`endif
                end
            end
            BUSY: begin
                if (Release || hold_expired) begin
                    timeout_d = hold_expired && !Release;
                    if (win_found) begin
                        idx_d   = win_idx;
                        last_d  = win_idx;
`ifdef RR_ARB_TIMEOUT_EN
                        cnt_d   = CNT_W'(1);
`endif
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        valid_d = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset seeds last_q at N_REQ-1 so requester 0 has first priority.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            last_q    <= SEL_W'(N_REQ - 1);
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    decoder_4to16 #(
        .SEL_W (SEL_W),
        .N_REQ (N_REQ)
    ) u_decoder (
        .sel_i (idx_q),
        .en_i  (valid_q),
        .dec_o (Grant)
    );

    assign Grant_Idx   = idx_q;
    assign Grant_Valid = valid_q;
    assign Timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Randomized and directed bench for rr_decode_arbiter against a behavioural model.
module tb_rr_decode_arbiter;

    localparam int N        = 16;
    localparam int HOLD_MAX = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [N-1:0]  Req = '0;
    logic          Release = 1'b0;
    logic [N-1:0]  Grant;
    logic [3:0]    Grant_Idx;
    logic          Grant_Valid;
    logic          Timeout;

    int checks = 0;
    int errors = 0;

    // Model state: owner index or -1 when idle.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_hold  = 0;
    bit m_tout  = 1'b0;

    always #5 Clk = ~Clk;

    rr_decode_arbiter #(
        .SEL_W    (4),
        .N_REQ    (N),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Req         (Req),
        .Release     (Release),
        .Grant       (Grant),
        .Grant_Idx   (Grant_Idx),
        .Grant_Valid (Grant_Valid),
        .Timeout     (Timeout)
    );

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_edge(input logic [N-1:0] req, input logic rel, input logic rst);
        bit forced;
        m_tout = 1'b0;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_hold = 0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                m_owner = rr_pick(req, m_last); m_last = m_owner; m_hold = 1;
            end
        end else begin
            forced = TO_EN && (m_hold == HOLD_MAX) && !rel;
            if (rel || forced) begin
                m_tout = forced;
                if (req != 0) begin
                    m_owner = rr_pick(req, m_last); m_last = m_owner; m_hold = 1;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end else begin
                m_hold++;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] one;
        one = N'(1);
        return (m_owner >= 0) ? (one << m_owner) : '0;
    endfunction

    function automatic logic [3:0] exp_idx();
        return (m_owner >= 0) ? 4'(m_owner) : 4'd0;
    endfunction

    task automatic step(input logic [N-1:0] req, input logic rel, input logic rst);
        Req = req; Release = rel; Rst = rst;
        @(posedge Clk);
        model_edge(req, rel, rst);
        #1;
    endtask

    task automatic test_reset();
        step('1, 1'b1, 1'b1);
        step('1, 1'b0, 1'b1);
        checks++;
        if ({Grant, Grant_Idx, Grant_Valid, Timeout} !== {16'h0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: grant=%h idx=%0d valid=%b tout=%b, want 0/0/0/0", Grant, Grant_Idx, Grant_Valid, Timeout);
        end
    endtask

    task automatic test_single();
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0001, 1'b0, 1'b0);
        checks++;
        if ({Grant, Grant_Idx, Grant_Valid} !== {16'h0001, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL single: grant=%h idx=%0d valid=%b, want 0001/0/1", Grant, Grant_Idx, Grant_Valid);
        end
    endtask

    task automatic test_wrap();
        step(16'h0000, 1'b0, 1'b1);
        step(16'hFFFF, 1'b0, 1'b0);
        for (int k = 1; k <= N; k++) begin
            step(16'hFFFF, 1'b1, 1'b0);
            checks++;
            if (Grant_Idx !== 4'(k % N) || Grant !== exp_grant() || Grant_Valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap[%0d]: idx=%0d grant=%h, want idx=%0d grant=%h", k, Grant_Idx, Grant, k % N, exp_grant());
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] want [3];
        logic [N-1:0] reqs [3];
        reqs[0] = 16'h0009; reqs[1] = 16'h0008; reqs[2] = 16'h0008;
        want[0] = 4'd0;     want[1] = 4'd3;     want[2] = 4'd3;
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0008, 1'b0, 1'b0);
        checks++;
        if (Grant_Idx !== 4'd3) begin
            errors++;
            $display("FAIL prio_owner3: idx=%0d, want 3", Grant_Idx);
        end
        for (int k = 0; k < 3; k++) begin
            step(reqs[k], 1'b1, 1'b0);
            checks++;
            if (Grant_Idx !== want[k] || Grant !== exp_grant()) begin
                errors++;
                $display("FAIL prio[%0d]: idx=%0d grant=%h, want idx=%0d grant=%h", k, Grant_Idx, Grant, want[k], exp_grant());
            end
        end
    endtask

    task automatic test_release_idle();
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0004, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        checks++;
        if ({Grant, Grant_Idx, Grant_Valid} !== {16'h0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL rel_to_idle: grant=%h idx=%0d valid=%b, want 0/0/0", Grant, Grant_Idx, Grant_Valid);
        end
        step(16'h0000, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        checks++;
        if ({Grant, Grant_Valid} !== {16'h0, 1'b0}) begin
            errors++;
            $display("FAIL rel_in_idle: grant=%h valid=%b, want 0/0", Grant, Grant_Valid);
        end
        // Owner dropping its request while busy does not end the grant.
        step(16'h0020, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        checks++;
        if (Grant !== 16'h0020 || Grant_Idx !== 4'd5) begin
            errors++;
            $display("FAIL hold_drop: grant=%h idx=%0d, want 0020/5", Grant, Grant_Idx);
        end
    endtask

    task automatic test_timeout();
        step(16'h0000, 1'b0, 1'b1);
        for (int c = 1; c <= HOLD_MAX; c++) begin
            step(16'h0030, 1'b0, 1'b0);
            checks++;
            if (Grant_Idx !== 4'd4 || Timeout !== 1'b0 || Grant_Valid !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: idx=%0d tout=%b, want idx=4 tout=0", c, Grant_Idx, Timeout);
            end
        end
        step(16'h0030, 1'b0, 1'b0);
        checks++;
        if (Grant_Idx !== exp_idx() || Timeout !== m_tout) begin
            errors++;
            $display("FAIL after_hold: idx=%0d tout=%b, want idx=%0d tout=%b", Grant_Idx, Timeout, exp_idx(), m_tout);
        end
        if (TO_EN) begin
            checks++;
            if (Grant_Idx !== 4'd5 || Timeout !== 1'b1) begin
                errors++;
                $display("FAIL timeout_pulse: idx=%0d tout=%b, want idx=5 tout=1", Grant_Idx, Timeout);
            end
            step(16'h0030, 1'b0, 1'b0);
            checks++;
            if (Timeout !== 1'b0 || Grant_Idx !== 4'd5) begin
                errors++;
                $display("FAIL timeout_once: idx=%0d tout=%b, want idx=5 tout=0", Grant_Idx, Timeout);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0080, 1'b0, 1'b0);
        checks++;
        if (Grant_Idx !== 4'd7 || Grant !== 16'h0080) begin
            errors++;
            $display("FAIL rst_setup: idx=%0d grant=%h, want 7/0080", Grant_Idx, Grant);
        end
        step(16'h0080, 1'b1, 1'b1);
        checks++;
        if ({Grant, Grant_Valid} !== {16'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid: grant=%h valid=%b, want 0/0", Grant, Grant_Valid);
        end
        step(16'h0080, 1'b0, 1'b0);
        checks++;
        if (Grant_Idx !== 4'd7 || Grant !== 16'h0080 || Grant_Valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_regrant: idx=%0d grant=%h valid=%b, want 7/0080/1", Grant_Idx, Grant, Grant_Valid);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic rel, rst;
        step(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            r   = N'($urandom) & N'($urandom) & ((($urandom % 4) == 0) ? 16'h0000 : 16'hFFFF);
            rel = ($urandom % 3) == 0;
            rst = ($urandom % 64) == 0;
            step(r, rel, rst);
            checks++;
            if (Grant !== exp_grant() || Grant_Idx !== exp_idx() || Grant_Valid !== (m_owner >= 0)
                || Timeout !== m_tout || !$onehot0(Grant)) begin
                errors++;
                $display("FAIL random[%0d]: grant=%h idx=%0d valid=%b tout=%b, want grant=%h idx=%0d valid=%b tout=%b",
                         c, Grant, Grant_Idx, Grant_Valid, Timeout, exp_grant(), exp_idx(), m_owner >= 0, m_tout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_priority();
        test_release_idle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
